// File: rtl/suprloco_frame_sigcap.sv
// ---------------------------------------------------------------------------
// suprloco_frame_sigcap
//
// Hardware frame grabber / signature generator for the video output bus.
// Raster coordinates are recovered purely from the active-video strobe:
// a long enough run of EN-low pixel ticks marks vertical blank, shorter
// runs are horizontal blank. Each active pixel is re-emitted with its (x,y)
// coordinates, 8-bit-per-channel colour and SOF/EOL/EOF markers. A CRC-32
// over every pixel of a frame plus line-length and line-count checks give
// a compact per-frame signature for hardware self-test.
//
// Ports
//   i_EMU_MCLK      master clock
//   i_EMU_RST       synchronous reset, active-high
//   i_VIDEO_CEN     pixel clock enable; video inputs are sampled only when high
//   i_VIDEO_EN      active-video strobe
//   i_VIDEO_R/G/B   CW-bit colour channels
//   o_PX_VALID      one-MCLK pixel strobe
//   o_PX_X/o_PX_Y   coordinates of the pixel flagged by o_PX_VALID
//   o_PX_RGB        {R8,G8,B8}, each channel bit-replicated from CW bits
//   o_SOF           asserted with the first pixel of a frame
//   o_EOL           one-MCLK pulse at the end of each line
//   o_EOF           one-MCLK pulse at the end of a frame
//   o_FRAME_CNT     number of completed frames (wraps)
//   o_FRAME_CRC     CRC-32 of the last completed frame
//   o_LINE_ERR      last frame contained a line whose length != H_ACTIVE
//   o_GEOM_ERR      last frame line count != V_ACTIVE
// ---------------------------------------------------------------------------
module suprloco_frame_sigcap #(
  parameter int CW         = 3,
  parameter int H_ACTIVE   = 256,
  parameter int V_ACTIVE   = 224,
  parameter int VBLANK_MIN = 64,
  parameter int XW         = 9
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_RST,
  input  logic          i_VIDEO_CEN,
  input  logic          i_VIDEO_EN,
  input  logic [CW-1:0] i_VIDEO_R,
  input  logic [CW-1:0] i_VIDEO_G,
  input  logic [CW-1:0] i_VIDEO_B,
  output logic          o_PX_VALID,
  output logic [XW-1:0] o_PX_X,
  output logic [XW-1:0] o_PX_Y,
  output logic [23:0]   o_PX_RGB,
  output logic          o_SOF,
  output logic          o_EOL,
  output logic          o_EOF,
  output logic [15:0]   o_FRAME_CNT,
  output logic [31:0]   o_FRAME_CRC,
  output logic          o_LINE_ERR,
  output logic          o_GEOM_ERR
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_LINE   = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  localparam logic [7:0]    GAP_MAX   = 8'(VBLANK_MIN);
  localparam logic [XW-1:0] XY_MAX    = {XW{1'b1}};
  localparam logic [XW-1:0] XY_ONE    = XW'(1);
  localparam logic [XW-1:0] H_ACT_C   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] V_ACT_C   = XW'(V_ACTIVE);
  localparam logic [31:0]   CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0]   CRC_INIT  = 32'hFFFFFFFF;

  // Replicate a CW-bit channel MSB-first into 8 bits: repeating the value
  // and keeping the top byte gives exactly the MSB-first replication.
  function automatic logic [7:0] expand_col(input logic [CW-1:0] c);
    logic [8*CW-1:0] rep;
    rep = {8{c}};
    return rep[8*CW-1 -: 8];
  endfunction

  // CRC-32 (poly 04C11DB7, MSB-first) over one 24-bit pixel in a single step.
  // The data word is shifted out from bit 23 (R[7]) down to bit 0 (B[0]).
  function automatic logic [31:0] crc32_px(input logic [31:0] crc,
                                           input logic [23:0] d);
    logic [31:0] c;
    logic [23:0] sh;
    logic        fb;
    c  = crc;
    sh = d;
    for (int i = 0; i < 24; i++) begin
      fb = c[31] ^ sh[23];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
      sh = {sh[22:0], 1'b0};
    end
    return c;
  endfunction

  state_t        state_r;
  logic [7:0]    gap_r;
  logic [XW-1:0] x_r;
  logic [XW-1:0] y_r;
  logic [31:0]   crc_r;
  logic          line_err_acc_r;

  logic [7:0]    gap_nxt_s;
  logic          gap_hit_s;
  logic [XW-1:0] x_inc_s;
  logic [XW-1:0] y_inc_s;
  logic [23:0]   pix_rgb_s;

  // Next blank-gap count plus saturating coordinate increments and colour expansion.
  always_comb begin
    gap_nxt_s = gap_r;
    if (i_VIDEO_EN) begin
      gap_nxt_s = 8'd0;
    end else if (gap_r == GAP_MAX) begin
      gap_nxt_s = gap_r;
    end else begin
      gap_nxt_s = gap_r + 8'd1;
    end

    gap_hit_s = (gap_nxt_s == GAP_MAX);

    x_inc_s = x_r;
    if (x_r == XY_MAX) begin
      x_inc_s = x_r;
    end else begin
      x_inc_s = x_r + XY_ONE;
    end

    y_inc_s = y_r;
    if (y_r == XY_MAX) begin
      y_inc_s = y_r;
    end else begin
      y_inc_s = y_r + XY_ONE;
    end

    pix_rgb_s = {expand_col(i_VIDEO_R), expand_col(i_VIDEO_G), expand_col(i_VIDEO_B)};
  end

  // Raster-recovery FSM with all registered outputs, sampled on CEN ticks only.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_r        <= ST_SYNC;
      gap_r          <= 8'd0;
      x_r            <= '0;
      y_r            <= '0;
      crc_r          <= CRC_INIT;
      line_err_acc_r <= 1'b0;
      o_PX_VALID     <= 1'b0;
      o_PX_X         <= '0;
      o_PX_Y         <= '0;
      o_PX_RGB       <= 24'h00_0000;
      o_SOF          <= 1'b0;
      o_EOL          <= 1'b0;
      o_EOF          <= 1'b0;
      o_FRAME_CNT    <= 16'h0000;
      o_FRAME_CRC    <= 32'h0000_0000;
      o_LINE_ERR     <= 1'b0;
      o_GEOM_ERR     <= 1'b0;
    end else begin
      // Strobes are single-MCLK; they drop again on the next clock, CEN or not.
      o_PX_VALID <= 1'b0;
      o_SOF      <= 1'b0;
      o_EOL      <= 1'b0;
      o_EOF      <= 1'b0;

      if (i_VIDEO_CEN) begin
        gap_r <= gap_nxt_s;

        case (state_r)
          // Nothing is trusted until a full vertical blank has been seen.
          ST_SYNC: begin
            if (gap_hit_s) begin
              state_r <= ST_VBLANK;
            end
          end

          // First active sample after vblank opens a new frame at (0,0).
          ST_VBLANK: begin
            if (i_VIDEO_EN) begin
              state_r        <= ST_LINE;
              y_r            <= '0;
              x_r            <= XY_ONE;
              line_err_acc_r <= 1'b0;
              crc_r          <= crc32_px(CRC_INIT, pix_rgb_s);
              o_PX_VALID     <= 1'b1;
              o_SOF          <= 1'b1;
              o_PX_X         <= '0;
              o_PX_Y         <= '0;
              o_PX_RGB       <= pix_rgb_s;
            end
          end

          ST_LINE: begin
            if (i_VIDEO_EN) begin
              x_r        <= x_inc_s;
              crc_r      <= crc32_px(crc_r, pix_rgb_s);
              o_PX_VALID <= 1'b1;
              o_PX_X     <= x_r;
              o_PX_Y     <= y_r;
              o_PX_RGB   <= pix_rgb_s;
            end else begin
              // x_r holds the number of pixels seen on this line.
              state_r <= ST_HBLANK;
              o_EOL   <= 1'b1;
              if (x_r != H_ACT_C) begin
                line_err_acc_r <= 1'b1;
              end
              y_r <= y_inc_s;
              x_r <= '0;
            end
          end

          // A short gap starts a new line; a gap reaching VBLANK_MIN ends the frame.
          ST_HBLANK: begin
            if (i_VIDEO_EN) begin
              state_r    <= ST_LINE;
              x_r        <= x_inc_s;
              crc_r      <= crc32_px(crc_r, pix_rgb_s);
              o_PX_VALID <= 1'b1;
              o_PX_X     <= x_r;
              o_PX_Y     <= y_r;
              o_PX_RGB   <= pix_rgb_s;
            end else if (gap_hit_s) begin
              // y_r was bumped at every EOL, so it equals the frame's line count.
              state_r     <= ST_VBLANK;
              o_EOF       <= 1'b1;
              o_FRAME_CRC <= ~crc_r;
              o_LINE_ERR  <= line_err_acc_r;
              o_GEOM_ERR  <= (y_r != V_ACT_C);
              o_FRAME_CNT <= o_FRAME_CNT + 16'd1;
            end
          end

          default: begin
            state_r <= ST_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_suprloco_frame_sigcap.sv
// ---------------------------------------------------------------------------
// Directed testbench for suprloco_frame_sigcap, run with a reduced raster
// (16x8 active, 16-tick hblank, 64-tick vblank) so every scenario stays short.
// A queue of expected pixels is filled by the stimulus tasks and drained by a
// negedge monitor; the frame CRC is recomputed byte-wise by a bench model.
// ---------------------------------------------------------------------------
module tb_suprloco_frame_sigcap;

  localparam int CW = 3;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int VB = 64;
  localparam int XW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic          en;
  logic [CW-1:0] r, g, b;

  logic          o_PX_VALID;
  logic [XW-1:0] o_PX_X, o_PX_Y;
  logic [23:0]   o_PX_RGB;
  logic          o_SOF, o_EOL, o_EOF;
  logic [15:0]   o_FRAME_CNT;
  logic [31:0]   o_FRAME_CRC;
  logic          o_LINE_ERR, o_GEOM_ERR;

  always #5 clk = ~clk;

  suprloco_frame_sigcap #(
    .CW(CW), .H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_MIN(VB), .XW(XW)
  ) dut (
    .i_EMU_MCLK (clk),
    .i_EMU_RST  (rst),
    .i_VIDEO_CEN(cen),
    .i_VIDEO_EN (en),
    .i_VIDEO_R  (r),
    .i_VIDEO_G  (g),
    .i_VIDEO_B  (b),
    .o_PX_VALID (o_PX_VALID),
    .o_PX_X     (o_PX_X),
    .o_PX_Y     (o_PX_Y),
    .o_PX_RGB   (o_PX_RGB),
    .o_SOF      (o_SOF),
    .o_EOL      (o_EOL),
    .o_EOF      (o_EOF),
    .o_FRAME_CNT(o_FRAME_CNT),
    .o_FRAME_CRC(o_FRAME_CRC),
    .o_LINE_ERR (o_LINE_ERR),
    .o_GEOM_ERR (o_GEOM_ERR)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [23:0]   rgb;
    logic          sof;
  } px_t;

  px_t         exp_q[$];
  px_t         mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          px_bad = 0;
  int          n_sof  = 0;
  int          n_eol  = 0;
  int          n_eof  = 0;
  logic [23:0] last_rgb = 24'h0;
  logic        cap_on = 1'b0;
  int          cen_per = 1;
  logic [31:0] crc_m = 32'hFFFFFFFF;
  logic [31:0] crc_ref_b = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp_v);
    end
  endtask

  // Expected 8-bit channel for a 3-bit input: c c c[2:1].
  function automatic logic [7:0] exp8(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // Classic MSB-first byte-wise CRC-32 step.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {d, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      v = v[31] ? ({v[30:0], 1'b0} ^ 32'h04C11DB7) : {v[30:0], 1'b0};
    end
    return v;
  endfunction

  function automatic logic [2:0] col(input int pat, input int x, input int y, input int ch);
    if (pat == 1) return 3'b101;
    return 3'((x + 3 * y + 5 * ch) % 8);
  endfunction

  // Pixel monitor: counts markers and compares every pixel with the queue.
  always @(negedge clk) begin
    if (o_SOF) n_sof++;
    if (o_EOL) n_eol++;
    if (o_EOF) n_eof++;
    if (o_PX_VALID) begin
      last_rgb = o_PX_RGB;
      if (exp_q.size() == 0) begin
        px_bad++;
      end else begin
        mon_e = exp_q.pop_front();
        if (o_PX_X !== mon_e.x || o_PX_Y !== mon_e.y ||
            o_PX_RGB !== mon_e.rgb || o_SOF !== mon_e.sof) px_bad++;
      end
    end
  end

  // One pixel tick; with cen_per > 1 the non-CEN cycles carry junk on EN/colour.
  task automatic tick(input logic e, input logic [2:0] rr, input logic [2:0] gg, input logic [2:0] bb);
    for (int k = 0; k < cen_per; k++) begin
      @(negedge clk);
      if (k == cen_per - 1) begin
        cen = 1'b1; en = e; r = rr; g = gg; b = bb;
      end else begin
        cen = 1'b0; en = 1'($urandom); r = 3'($urandom); g = 3'($urandom); b = 3'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cen = 1'b0; en = 1'b0;
    end
  endtask

  task automatic blank(input int n);
    repeat (n) tick(1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic send_line(input int len, input int y, input int pat);
    logic [2:0] cr, cg, cb;
    px_t        pe;
    for (int x = 0; x < len; x++) begin
      cr = col(pat, x, y, 0);
      cg = col(pat, x, y, 1);
      cb = col(pat, x, y, 2);
      if (cap_on) begin
        pe.x   = XW'(x);
        pe.y   = XW'(y);
        pe.rgb = {exp8(cr), exp8(cg), exp8(cb)};
        pe.sof = (x == 0 && y == 0);
        exp_q.push_back(pe);
        crc_m = crc_byte(crc_byte(crc_byte(crc_m, pe.rgb[23:16]), pe.rgb[15:8]), pe.rgb[7:0]);
      end
      tick(1'b1, cr, cg, cb);
    end
  endtask

  // nl lines; line short_y is one pixel short; hblank after line long_y is 63 ticks.
  task automatic send_frame(input int nl, input int short_y, input int long_y, input int pat);
    crc_m = 32'hFFFFFFFF;
    for (int y = 0; y < nl; y++) begin
      send_line((y == short_y) ? H - 1 : H, y, pat);
      if (y < nl - 1) blank((y == long_y) ? 63 : 16);
    end
    blank(VB);
    idle(3);
  endtask

  task automatic check_frame(input string t, input logic [15:0] cnt, input logic le, input logic ge,
                             input int eof0, input int eol0, input int sof0, input int nl);
    chk({t, ".cnt"},     32'(o_FRAME_CNT), 32'(cnt));
    chk({t, ".crc"},     o_FRAME_CRC, ~crc_m);
    chk({t, ".line_err"}, 32'(o_LINE_ERR), 32'(le));
    chk({t, ".geom_err"}, 32'(o_GEOM_ERR), 32'(ge));
    chk({t, ".eof"},     32'(n_eof - eof0), 32'd1);
    chk({t, ".eol"},     32'(n_eol - eol0), 32'(nl));
    chk({t, ".sof"},     32'(n_sof - sof0), 32'd1);
    chk({t, ".pixels"},  32'(px_bad), 32'd0);
    chk({t, ".drained"}, 32'(exp_q.size()), 32'd0);
    px_bad = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running at %0t, want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int e0, l0, s0;
    rst = 1'b1; cen = 1'b0; en = 1'b0; r = 3'd0; g = 3'd0; b = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(o_PX_VALID), 32'd0);
    chk("rst.cnt",   32'(o_FRAME_CNT), 32'd0);
    chk("rst.crc",   o_FRAME_CRC, 32'd0);
    chk("rst.errs",  32'({o_LINE_ERR, o_GEOM_ERR}), 32'd0);
    chk("rst.rgb",   32'(o_PX_RGB), 32'd0);
    rst = 1'b0;

    // 1: stream starts mid-raster; the first frame is not captured.
    e0 = n_eof;
    send_frame(V, -1, -1, 0);
    chk("t1a.no_px",  32'(px_bad), 32'd0);
    chk("t1a.no_eof", 32'(n_eof - e0), 32'd0);
    chk("t1a.cnt",    32'(o_FRAME_CNT), 32'd0);
    px_bad = 0;
    cap_on = 1'b1;
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, -1, -1, 0);
    crc_ref_b = ~crc_m;
    check_frame("t1b", 16'd1, 1'b0, 1'b0, e0, l0, s0, V);
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, -1, -1, 0);
    check_frame("t1c", 16'd2, 1'b0, 1'b0, e0, l0, s0, V);

    // 2: constant colour 3'b101 expands to B6 on every channel.
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, -1, -1, 1);
    check_frame("t2", 16'd3, 1'b0, 1'b0, e0, l0, s0, V);
    chk("t2.rgb", 32'(last_rgb), 32'h00B6B6B6);

    // 3: one short line flags LINE_ERR; the next clean frame clears it.
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, 3, -1, 0);
    check_frame("t3a", 16'd4, 1'b1, 1'b0, e0, l0, s0, V);
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, -1, -1, 0);
    check_frame("t3b", 16'd5, 1'b0, 1'b0, e0, l0, s0, V);

    // 4: one line missing plus a 63-tick hblank inside the frame.
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V - 1, -1, 2, 0);
    check_frame("t4", 16'd6, 1'b0, 1'b1, e0, l0, s0, V - 1);

    // 5: CEN at 1/8 MCLK with junk between enables; same result as the CEN=1 frame.
    cen_per = 8;
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, -1, -1, 0);
    cen_per = 1;
    check_frame("t5", 16'd7, 1'b0, 1'b0, e0, l0, s0, V);
    chk("t5.crc_vs_cen1", o_FRAME_CRC, crc_ref_b);

    // 6: reset in the middle of a frame.
    e0 = n_eof;
    crc_m = 32'hFFFFFFFF;
    for (int y = 0; y < 5; y++) begin
      send_line(H, y, 0);
      blank(16);
    end
    send_line(7, 5, 0);
    @(negedge clk);
    rst = 1'b1; cen = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6.rst_valid", 32'(o_PX_VALID), 32'd0);
    chk("t6.rst_cnt",   32'(o_FRAME_CNT), 32'd0);
    chk("t6.rst_crc",   o_FRAME_CRC, 32'd0);
    chk("t6.rst_xy",    32'({o_PX_X, o_PX_Y}), 32'd0);
    chk("t6.rst_pipe",  32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    cap_on = 1'b0;
    blank(16);
    for (int y = 6; y < V; y++) begin
      send_line(H, y, 0);
      if (y < V - 1) blank(16);
    end
    blank(VB);
    idle(3);
    chk("t6.no_eof", 32'(n_eof - e0), 32'd0);
    chk("t6.no_px",  32'(px_bad), 32'd0);
    chk("t6.cnt0",   32'(o_FRAME_CNT), 32'd0);
    px_bad = 0;
    cap_on = 1'b1;
    e0 = n_eof; l0 = n_eol; s0 = n_sof;
    send_frame(V, -1, -1, 0);
    check_frame("t6.resync", 16'd1, 1'b0, 1'b0, e0, l0, s0, V);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
